// File: rtl/ysyx_220053_mem_arb.sv
// Two-requester (instruction fetch / load-store) arbiter onto a single memory port.
// One transaction in flight at a time; round-robin on ties; responses routed to the owner.
module ysyx_220053_mem_arb #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,

  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wmask,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,

  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,

  output logic            owner,
  output logic            busy,
  output logic            err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state_reg, state_next;
  logic              owner_reg;
  logic              last_reg;
  logic              err_reg;
  logic              we_reg;
  logic [AW-1:0]     addr_reg;
  logic [DW-1:0]     wdata_reg;
  logic [DW/8-1:0]   wmask_reg;

  logic              pick_ls;
  logic              launch;
  logic              accept;
  logic              respond;

  // LSU wins when it is the only requester, or on a tie when IF was served last.
  assign pick_ls = ls_req & (~if_req | ~last_reg);
  assign launch  = (state_reg == S_IDLE) & (if_req | ls_req);
  assign accept  = (state_reg == S_REQ) & mem_ready;
  assign respond = (state_reg == S_WAIT) & mem_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (launch)  state_next = S_REQ;
      S_REQ:   if (accept)  state_next = S_WAIT;
      S_WAIT:  if (respond) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    busy      = 1'b1;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    case (state_reg)
      S_IDLE: busy = 1'b0;
      S_REQ: begin
        mem_req = 1'b1;
        if_gnt  = mem_ready & ~owner_reg;
        ls_gnt  = mem_ready & owner_reg;
      end
      S_WAIT: begin
        if_rvalid = mem_rvalid & ~owner_reg;
        ls_rvalid = mem_rvalid & owner_reg;
      end
      default: busy = 1'b0;
    endcase
  end

  // Request fields are frozen at arbitration so later requester wiggles cannot leak through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wmask_reg <= '0;
    end else if (launch) begin
      owner_reg <= pick_ls;
      if (pick_ls) begin
        we_reg    <= ls_we;
        addr_reg  <= ls_addr;
        wdata_reg <= ls_wdata;
        wmask_reg <= ls_wmask;
      end else begin
        we_reg    <= 1'b0;
        addr_reg  <= if_addr;
        wdata_reg <= '0;
        wmask_reg <= '0;
      end
    end
  end

  // A response outside WAIT (including one coincident with acceptance) is a protocol error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      if (accept) begin
        last_reg <= owner_reg;
      end
      if (mem_rvalid && (state_reg != S_WAIT)) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wmask = wmask_reg;
  assign owner     = owner_reg;
  assign err       = err_reg;
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_ysyx_220053_mem_arb.sv
// Directed and randomized checks of the IF/LSU memory arbiter against a small
// round-robin reference model (last-served bit, captured fields, sticky error).
module tb_ysyx_220053_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [63:0] if_rdata;
  logic        ls_req, ls_we;
  logic [63:0] ls_addr, ls_wdata;
  logic [7:0]  ls_wmask;
  logic        ls_gnt, ls_rvalid;
  logic [63:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready, mem_rvalid;
  logic [63:0] mem_rdata;
  logic        owner, busy, err;

  int   total = 0;
  int   bad   = 0;
  logic last_srv = 1'b0;  // model: 0 = IF served last, 1 = LSU
  logic err_exp  = 1'b0;  // model: sticky protocol error

  ysyx_220053_mem_arb #(.AW(64), .DW(64)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_if_gnt"}, 64'(if_gnt), 64'd0);
    chk({tag, "_ls_gnt"}, 64'(ls_gnt), 64'd0);
    chk({tag, "_if_rvalid"}, 64'(if_rvalid), 64'd0);
    chk({tag, "_ls_rvalid"}, 64'(ls_rvalid), 64'd0);
  endtask

  // Entered in an IDLE cycle with requester inputs already driven; returns in the
  // IDLE cycle after the response.
  task automatic run_txn(input int rdy_wait, input int rv_wait, input logic exp_own,
                         input logic [63:0] e_addr, input logic e_we, input logic [63:0] e_wdata,
                         input logic [7:0] e_mask, input logic [63:0] rdata,
                         input bit drop, input bit spur);
    logic [63:0] s_if_addr, s_ls_addr, s_ls_wdata;
    logic        s_ls_we;
    logic [7:0]  s_ls_wmask;
    logic        g;
    s_if_addr = if_addr; s_ls_addr = ls_addr; s_ls_wdata = ls_wdata;
    s_ls_we = ls_we; s_ls_wmask = ls_wmask;
    #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_mem_req", 64'(mem_req), 64'd0);
    chk_quiet("idle");
    tick;
    for (int i = 0; i <= rdy_wait; i++) begin
      g          = (i == rdy_wait);
      mem_ready  = g;
      mem_rvalid = spur && g;
      if (i == 1) begin
        if (exp_own) begin
          ls_addr = {$urandom, $urandom}; ls_wdata = {$urandom, $urandom};
          ls_we = ~ls_we; ls_wmask = ~ls_wmask;
        end else begin
          if_addr = {$urandom, $urandom};
        end
        if (drop) begin
          if (exp_own) ls_req = 1'b0; else if_req = 1'b0;
        end
      end
      #1;
      chk("req_mem_req", 64'(mem_req), 64'd1);
      chk("req_busy", 64'(busy), 64'd1);
      chk("req_owner", 64'(owner), 64'(exp_own));
      chk("req_addr", mem_addr, e_addr);
      chk("req_we", 64'(mem_we), 64'(e_we));
      chk("req_wdata", mem_wdata, e_wdata);
      chk("req_wmask", 64'(mem_wmask), 64'(e_mask));
      chk("req_if_gnt", 64'(if_gnt), 64'(g & ~exp_own));
      chk("req_ls_gnt", 64'(ls_gnt), 64'(g & exp_own));
      chk("req_if_rvalid", 64'(if_rvalid), 64'd0);
      chk("req_ls_rvalid", 64'(ls_rvalid), 64'd0);
      tick;
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    if_addr = s_if_addr; ls_addr = s_ls_addr; ls_wdata = s_ls_wdata;
    ls_we = s_ls_we; ls_wmask = s_ls_wmask;
    for (int i = 0; i <= rv_wait; i++) begin
      g          = (i == rv_wait);
      mem_rvalid = g;
      mem_rdata  = g ? rdata : {$urandom, $urandom};
      #1;
      chk("wait_mem_req", 64'(mem_req), 64'd0);
      chk("wait_busy", 64'(busy), 64'd1);
      chk("wait_if_gnt", 64'(if_gnt), 64'd0);
      chk("wait_ls_gnt", 64'(ls_gnt), 64'd0);
      chk("wait_if_rvalid", 64'(if_rvalid), 64'(g & ~exp_own));
      chk("wait_ls_rvalid", 64'(ls_rvalid), 64'(g & exp_own));
      if (g) chk("wait_rdata", exp_own ? ls_rdata : if_rdata, rdata);
      tick;
    end
    mem_rvalid = 1'b0;
    last_srv = exp_own;
    if (spur) err_exp = 1'b1;
    #1;
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_err", 64'(err), 64'(err_exp));
  endtask

  task automatic do_reset;
    rst = 1'b0;
    #1;
    chk("rst_state_busy", 64'(busy), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk_quiet("rst");
    tick;
    rst = 1'b1;
    last_srv = 1'b0;
    err_exp  = 1'b0;
  endtask

  initial begin
    logic [1:0]  r;
    logic        win;
    logic [63:0] rd;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick;
    do_reset;

    // IF-only fetch at minimum latency.
    if_req = 1'b1; if_addr = 64'h8000_0000;
    run_txn(0, 0, 1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'd0, 64'h0000_0013_0010_0093, 1'b0, 1'b0);
    if_req = 1'b0;

    // Tie after reset-state last-served: LSU, IF, LSU with both held.
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_1000;
    ls_wdata = 64'h1111; ls_wmask = 8'hFF;
    run_txn(0, 0, 1'b1, 64'h8000_1000, 1'b0, 64'h1111, 8'hFF, 64'hA1, 1'b0, 1'b0);
    run_txn(1, 0, 1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'd0, 64'hA2, 1'b0, 1'b0);
    run_txn(0, 2, 1'b1, 64'h8000_1000, 1'b0, 64'h1111, 8'hFF, 64'hA3, 1'b0, 1'b0);
    if_req = 1'b0; ls_req = 1'b0;

    // LSU write with three stall cycles.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_2000; ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
    run_txn(3, 1, 1'b1, 64'h8000_2000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 64'h0, 1'b0, 1'b0);
    ls_req = 1'b0;

    // Randomized traffic against the round-robin model.
    for (int n = 0; n < 40; n++) begin
      r = 2'($urandom_range(1, 3));
      if_req = r[0]; ls_req = r[1];
      if_addr = {$urandom, $urandom}; ls_addr = {$urandom, $urandom};
      ls_wdata = {$urandom, $urandom}; ls_we = 1'($urandom); ls_wmask = 8'($urandom);
      rd = {$urandom, $urandom};
      win = (if_req && ls_req) ? ~last_srv : ls_req;
      if (win)
        run_txn($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, ls_addr, ls_we, ls_wdata,
                ls_wmask, rd, ($urandom_range(0, 3) == 0), 1'b0);
      else
        run_txn($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, if_addr, 1'b0, 64'd0,
                8'd0, rd, ($urandom_range(0, 3) == 0), 1'b0);
    end
    if_req = 1'b0; ls_req = 1'b0;

    // Spurious response in IDLE sets a sticky error and is not routed.
    tick;
    mem_rvalid = 1'b1; mem_rdata = 64'h5A5A;
    #1;
    chk_quiet("spur_idle");
    tick;
    mem_rvalid = 1'b0;
    #1;
    chk("spur_err", 64'(err), 64'd1);
    tick;
    #1;
    chk("spur_err_sticky", 64'(err), 64'd1);
    err_exp = 1'b1;

    // Reset while the LSU transaction sits in WAIT; a late response then flags err.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_3000;
    tick;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0; ls_req = 1'b0;
    #1;
    chk("wait_before_rst_busy", 64'(busy), 64'd1);
    do_reset;
    mem_rvalid = 1'b1; mem_rdata = 64'h77;
    #1;
    chk_quiet("late_rsp");
    tick;
    mem_rvalid = 1'b0;
    #1;
    chk("late_rsp_err", 64'(err), 64'd1);
    err_exp = 1'b1;

    if_req = 1'b1; if_addr = 64'h8000_0040;
    run_txn(1, 1, 1'b0, 64'h8000_0040, 1'b0, 64'd0, 8'd0, 64'hBEEF, 1'b0, 1'b0);
    if_req = 1'b0;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_4000; ls_wdata = 64'h42; ls_wmask = 8'h01;
    run_txn(0, 0, 1'b1, 64'h8000_4000, 1'b1, 64'h42, 8'h01, 64'd0, 1'b0, 1'b0);
    ls_req = 1'b0;

    // Reset clears last-served back to IF; response coincident with acceptance is spurious.
    do_reset;
    if_req = 1'b1; if_addr = 64'h8000_0080;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_5000; ls_wdata = 64'h9; ls_wmask = 8'h3;
    run_txn(0, 1, 1'b1, 64'h8000_5000, 1'b0, 64'h9, 8'h3, 64'hC0DE, 1'b0, 1'b1);
    run_txn(0, 0, 1'b0, 64'h8000_0080, 1'b0, 64'd0, 8'd0, 64'hF00D, 1'b0, 1'b0);
    if_req = 1'b0; ls_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_220053_mem_arb.md
YSYX_220053_MEM_ARB -- requirements
Module: ysyx_220053_mem_arb

Interface
REQ-001 Parameter AW, default 64, address width.
REQ-002 Parameter DW, default 64, data width; strobe width is DW/8.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  instruction-fetch read request, held until if_gnt.
REQ-007 if_addr  in  AW  fetch address, stable while if_req=1.
REQ-008 if_gnt  out  1  one-cycle pulse: fetch request accepted by memory.
REQ-009 if_rvalid  out  1  one-cycle pulse: if_rdata valid.
REQ-010 if_rdata  out  DW  fetch read data.
REQ-011 ls_req  in  1  load/store request, held until ls_gnt.
REQ-012 ls_we  in  1  1=write, 0=read.
REQ-013 ls_addr / ls_wdata / ls_wmask  in  AW / DW / DW/8  LSU address, write data, byte strobes; stable while ls_req=1.
REQ-014 ls_gnt  out  1  one-cycle pulse: LSU request accepted.
REQ-015 ls_rvalid  out  1  one-cycle pulse: read data valid or write acknowledged.
REQ-016 ls_rdata  out  DW  LSU read data.
REQ-017 mem_req  out  1  memory request valid.
REQ-018 mem_we / mem_addr / mem_wdata / mem_wmask  out  1 / AW / DW / DW/8  registered request fields.
REQ-019 mem_ready  in  1  memory accepts the request this cycle when mem_req=1.
REQ-020 mem_rvalid / mem_rdata  in  1 / DW  memory response; one response per accepted request, read or write.
REQ-021 owner  out  1  0=IF, 1=LSU, the owner of the current transaction.
REQ-022 busy  out  1  1 when the state is not IDLE.
REQ-023 err  out  1  sticky flag for a protocol error.

Function
REQ-024 The FSM SHALL have three states: IDLE, REQ, WAIT; at most one transaction is outstanding.
REQ-025 In IDLE, when a requester is pending, the block SHALL:
- pick the winner;
- register its fields into mem_* (IF: mem_we=0, wdata=0, wmask=0);
- set owner;
- move to REQ on the next edge.
REQ-026 Arbitration SHALL be round-robin: if both request, the winner is the requester not served last; if one requests, it wins.
REQ-027 The last-served bit SHALL reset to IF, so the first tie goes to LSU.
REQ-028 In REQ, mem_req SHALL be 1 and mem_* SHALL stay constant until mem_ready=1.
REQ-029 When mem_ready=1 in REQ, the block SHALL:
- pulse the owner's gnt in that same cycle;
- update last-served;
- go to WAIT.
REQ-030 In WAIT, mem_req SHALL be 0; on mem_rvalid=1 the block SHALL pulse the owner's rvalid with xx_rdata=mem_rdata (combinational passthrough) and go to IDLE.
REQ-031 Minimum latency SHALL be: req at cycle 0 -> mem_req at cycle 1 -> gnt at cycle 1 if mem_ready=1 -> rvalid at cycle 2 if mem_rvalid=1 -> a new arbitration in IDLE at cycle 3.
REQ-032 A request asserted during REQ or WAIT SHALL wait, with no gnt, until IDLE.
REQ-033 The non-owner's gnt and rvalid SHALL stay 0 at all times.
REQ-034 mem_rvalid=1 in IDLE or REQ SHALL be ignored for routing and SHALL set err.
REQ-035 mem_rvalid=1 and mem_ready=1 arriving in the same REQ cycle SHALL be treated as a spurious response, because the response cannot precede acceptance.
REQ-036 Requester inputs that change while req=1 SHALL have no effect after capture.
REQ-037 A requester that drops req before gnt while the block is in REQ SHALL NOT abort the transaction, and the transaction SHALL complete.

Reset
REQ-038 While rst=0, all of the following SHALL be forced asynchronously:
- state=IDLE;
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0;
- owner=0, busy=0, err=0, last-served=IF;
- all gnt/rvalid=0.
REQ-039 Reset during REQ or WAIT SHALL abandon the transaction; a late mem_rvalid after release SHALL set err.
REQ-040 The first arbitration SHALL occur in the first IDLE cycle after rst rises.

Verification
REQ-041 IF-only: if_req=1, if_addr=0x80000000, mem_ready=1 at cycle 1, mem_rvalid=1 with rdata=0x00000013_00100093 at cycle 2 -> mem_addr=0x80000000, if_gnt at cycle 1, if_rvalid at cycle 2 with the same data, ls_* quiet.
REQ-042 Tie: if_req and ls_req (read, 0x80001000) rise together after reset -> LSU served first, then IF; with both held, grants alternate LSU, IF, LSU.
REQ-043 LSU write: ls_we=1, addr 0x80002000, wdata 0xDEADBEEF, wmask 0x0F, mem_ready held 0 for 3 cycles -> mem_* stable for the 3 stall cycles, ls_gnt when ready, ls_rvalid on the ack.
REQ-044 Spurious response: mem_rvalid=1 in IDLE -> err=1 and stays 1; no rvalid pulses.
REQ-045 Reset in WAIT: rst=0 for one cycle while owner=LSU -> outputs at reset values immediately; next if_req is served normally.
